// File: rtl/sdr_pkg.sv
// -----------------------------------------------------------------------------
// sdr_pkg
// Shared definitions for the SDRAM request arbiter: arbiter state encoding,
// default address/data widths and a helper that sizes requester indices.
// No ports (package).
// -----------------------------------------------------------------------------
package sdr_pkg;

    // Defaults match the SDRAM controller's user_addr / data_in widths.
    localparam int SDR_AW = 23;
    localparam int SDR_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } sdr_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdr_arb_pick.sv
// -----------------------------------------------------------------------------
// sdr_arb_pick
// Combinational winner select. Scans the request vector starting at index
// 'ptr' and wrapping around; the first set request wins. With ptr held at 0
// this degenerates to fixed priority, lowest index first.
// Ports:
//   req  in  NREQ  pending requests
//   ptr  in  IW    index where the scan starts
//   gnt  out NREQ  one-hot winner (all zero when no request)
//   idx  out IW    binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module sdr_arb_pick
    import sdr_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Walk the candidates from lowest priority to highest so the last hit
    // written is the winner; avoids a separate "found" flag.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sdr_arbiter.sv
// -----------------------------------------------------------------------------
// sdr_arbiter
// Multi-requester front end for the SDRAM controller. Grants one single-word
// request at a time, issues it with a one-cycle in_valid pulse, waits for the
// read data (or the end of the write) and routes read data to the owner.
// A watchdog answers a read with rsp_err=1 if no data arrives within TMO
// cycles of issue.
//
// Build option: define SDR_ARB_RR_EN for round-robin arbitration (scan
// starts after the last winner); otherwise fixed priority, lowest index wins.
//
// Ports (req_* buses flattened, requester i at slice i):
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/rw/addr/wdata requests, held until req_ack
//   req_ack                 one-cycle pulse when the request is issued
//   rsp_valid               one-cycle pulse per requester, read completion
//   rsp_rdata, rsp_err      shared read data, timeout flag
//   sdr_addr/rw/wdata       request fields to the controller
//   sdr_in_valid            one-cycle issue pulse to the controller
//   sdr_busy, sdr_rdata, sdr_out_valid   controller status and read data
// -----------------------------------------------------------------------------
module sdr_arbiter
    import sdr_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = SDR_AW,
    parameter int DW   = SDR_DW,
    parameter int TMO  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_rw,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [AW-1:0]      sdr_addr,
    output logic               sdr_rw,
    output logic [DW-1:0]      sdr_wdata,
    output logic               sdr_in_valid,
    input  logic               sdr_busy,
    input  logic [DW-1:0]      sdr_rdata,
    input  logic               sdr_out_valid
);

    localparam int IW = idx_width(NREQ);

    // Unpack the flattened request buses.
    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
    endgenerate

    sdr_state_e      state_q, state_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [AW-1:0]   sdr_addr_q, sdr_addr_d;
    logic            sdr_rw_q, sdr_rw_d;
    logic [DW-1:0]   sdr_wdata_q, sdr_wdata_d;
    logic            sdr_in_valid_q, sdr_in_valid_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [7:0]      wdog_q, wdog_d;

    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] win_gnt;
    logic [IW-1:0]   win_idx;
    logic            issue;

    // Only one transaction in flight: issue needs IDLE and an idle controller.
    assign issue = (state_q == IDLE) && !sdr_busy && (|req_valid);

    sdr_arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

`ifdef SDR_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Pointer moves past the winner, and only when a request is issued.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_d        = state_q;
        req_ack_d      = '0;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = 1'b0;
        sdr_in_valid_d = 1'b0;
        sdr_addr_d     = sdr_addr_q;
        sdr_rw_d       = sdr_rw_q;
        sdr_wdata_d    = sdr_wdata_q;
        owner_d        = owner_q;
        wdog_d         = wdog_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    sdr_in_valid_d = 1'b1;
                    sdr_addr_d     = addr_arr[win_idx];
                    sdr_rw_d       = req_rw[win_idx];
                    sdr_wdata_d    = wdata_arr[win_idx];
                    req_ack_d      = win_gnt;
                    owner_d        = win_idx;
                    wdog_d         = '0;
                    state_d        = req_rw[win_idx] ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD: begin
                // wdog_q equals the cycles elapsed since issue, so hitting
                // TMO-1 here puts the error response exactly TMO after issue.
                if (sdr_out_valid) begin
                    rsp_valid_d = NREQ'(1) << owner_q;
                    rsp_rdata_d = sdr_rdata;
                    state_d     = IDLE;
                end else if (wdog_q == 8'(TMO - 1)) begin
                    rsp_valid_d = NREQ'(1) << owner_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            WAIT_WR: begin
                // The controller only raises busy the cycle after in_valid,
                // so busy is meaningless while our pulse is still out.
                if (!sdr_in_valid_q && !sdr_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            req_ack_q      <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            sdr_addr_q     <= '0;
            sdr_rw_q       <= 1'b0;
            sdr_wdata_q    <= '0;
            sdr_in_valid_q <= 1'b0;
            owner_q        <= '0;
            wdog_q         <= '0;
        end else begin
            state_q        <= state_d;
            req_ack_q      <= req_ack_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            sdr_addr_q     <= sdr_addr_d;
            sdr_rw_q       <= sdr_rw_d;
            sdr_wdata_q    <= sdr_wdata_d;
            sdr_in_valid_q <= sdr_in_valid_d;
            owner_q        <= owner_d;
            wdog_q         <= wdog_d;
        end
    end

    assign req_ack      = req_ack_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign sdr_addr     = sdr_addr_q;
    assign sdr_rw       = sdr_rw_q;
    assign sdr_wdata    = sdr_wdata_q;
    assign sdr_in_valid = sdr_in_valid_q;

endmodule
